// File: rtl/msrv32_ahb_pkg.sv
// Shared AHB-lite encodings for the msrv32 data-memory slave: HTRANS codes,
// slave FSM state codes and HRESP response codes.
package msrv32_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

endpackage

// File: rtl/msrv32_dmem_ram.sv
// Synchronous word RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module msrv32_dmem_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Read-first: a same-address write in this cycle is not visible on rdata_o.
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/msrv32_ahb_dmem.sv
// AHB-lite data-memory slave: configurable wait states, ERROR response for
// out-of-range addresses, and write-to-read forwarding for back-to-back transfers.
module msrv32_ahb_dmem
    import msrv32_ahb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] ms_riscv32_mp_dmaddr_in,
    input  logic [31:0] ms_riscv32_mp_dmdata_in,
    input  logic        ms_riscv32_mp_dmwr_req_in,
    input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
    input  logic [1:0]  ms_riscv32_mp_data_htrans_in,
    output logic [31:0] ms_riscv32_mp_data_out,
    output logic        ms_riscv32_mp_data_hready_out,
    output logic        ms_riscv32_mp_hresp_out
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    logic [2:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    fwd_mask_q;
    logic [31:0]   fwd_data_q;

    logic          is_xfer, accept, in_range, hready;
    logic [AW-1:0] bus_word, raddr;
    logic [3:0]    commit_we;
    logic [31:0]   ram_rdata, rd_merged;

    always_comb begin
        unique case (ms_riscv32_mp_data_htrans_in)
            HTRANS_NONSEQ, HTRANS_SEQ: is_xfer = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  is_xfer = 1'b0;
            default:                   is_xfer = 1'b0;
        endcase
    end

    assign hready    = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign accept    = hready && is_xfer;
    assign in_range  = ({1'b0, ms_riscv32_mp_dmaddr_in} >= {1'b0, BASE_ADDR}) &&
                       ({1'b0, ms_riscv32_mp_dmaddr_in} < END_ADDR);
    assign bus_word  = AW'((ms_riscv32_mp_dmaddr_in - BASE_ADDR) >> 2);
    assign commit_we = (state_q == ST_DATA && wr_q) ? mask_q : '0;
    // The read port tracks the bus address on acceptance so data is ready in the next cycle.
    assign raddr     = accept ? bus_word : addr_q;

    always_comb begin
        for (int unsigned b = 0; b < 4; b++) begin
            rd_merged[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : ram_rdata[8*b +: 8];
        end
    end

    assign ms_riscv32_mp_data_hready_out = hready;
    assign ms_riscv32_mp_hresp_out       = (state_q == ST_ERR1 || state_q == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
    assign ms_riscv32_mp_data_out        = (state_q == ST_DATA && !wr_q) ? rd_merged : data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        mask_d  = mask_q;
        data_d  = data_q;
        if (state_q == ST_DATA && !wr_q) begin
            data_d = rd_merged;
        end
        if (accept) begin
            addr_d = bus_word;
            wr_d   = ms_riscv32_mp_dmwr_req_in;
            mask_d = ms_riscv32_mp_dmwr_mask_in;
            if (!in_range) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES == 0) begin
                state_d = ST_DATA;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = 3'(WAIT_STATES - 1);
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 3'd0) state_d = ST_DATA;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                ST_ERR1: state_d = ST_ERR2;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            mask_q     <= '0;
            data_q     <= '0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            fwd_mask_q <= (raddr == addr_q) ? commit_we : '0;
            fwd_data_q <= ms_riscv32_mp_dmdata_in;
        end
    end

    msrv32_dmem_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk_i   (ms_riscv32_mp_clk_in),
        .we_i    (commit_we),
        .waddr_i (addr_q),
        .wdata_i (ms_riscv32_mp_dmdata_in),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_msrv32_ahb_dmem.sv
// Scoreboard bench for msrv32_ahb_dmem: two instances (0 and 2 wait states)
// driven by a pipelined AHB master and checked against a word-array model.
module tb_msrv32_ahb_dmem;
    import msrv32_ahb_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned WS0   = 0;
    localparam int unsigned WS1   = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0][31:0] haddr, hwdata, rdata;
    logic [1:0]       hwrite, hready, hresp;
    logic [1:0][3:0]  hmask;
    logic [1:0][1:0]  htrans;

    always #5 clk = ~clk;

    msrv32_ahb_dmem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS0)) u_dut0 (
        .ms_riscv32_mp_clk_in         (clk),
        .ms_riscv32_mp_rst_in         (rst_n),
        .ms_riscv32_mp_dmaddr_in      (haddr[0]),
        .ms_riscv32_mp_dmdata_in      (hwdata[0]),
        .ms_riscv32_mp_dmwr_req_in    (hwrite[0]),
        .ms_riscv32_mp_dmwr_mask_in   (hmask[0]),
        .ms_riscv32_mp_data_htrans_in (htrans[0]),
        .ms_riscv32_mp_data_out       (rdata[0]),
        .ms_riscv32_mp_data_hready_out(hready[0]),
        .ms_riscv32_mp_hresp_out      (hresp[0])
    );

    msrv32_ahb_dmem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS1)) u_dut1 (
        .ms_riscv32_mp_clk_in         (clk),
        .ms_riscv32_mp_rst_in         (rst_n),
        .ms_riscv32_mp_dmaddr_in      (haddr[1]),
        .ms_riscv32_mp_dmdata_in      (hwdata[1]),
        .ms_riscv32_mp_dmwr_req_in    (hwrite[1]),
        .ms_riscv32_mp_dmwr_mask_in   (hmask[1]),
        .ms_riscv32_mp_data_htrans_in (htrans[1]),
        .ms_riscv32_mp_data_out       (rdata[1]),
        .ms_riscv32_mp_data_hready_out(hready[1]),
        .ms_riscv32_mp_hresp_out      (hresp[1])
    );

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] data;
    } op_t;

    typedef struct {
        int          lat;
        logic        err;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    op_t         ops[$];
    exp_t        exp_q[$];
    logic [31:0] mem_m [int];
    logic [31:0] pool [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h20, 32'hFFC};
    logic [31:0] bad  [4] = '{32'h1000, 32'h2000, 32'h8000_0000, 32'hFFFF_FFF0};
    logic [1:0][31:0] hold = '0;
    int cur = 0;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, cur, $time, act, exp);
        end
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        longint unsigned lo = 64'(BASE);
        longint unsigned hi = lo + 64'(DEPTH) * 4;
        return (64'(a) >= lo) && (64'(a) < hi);
    endfunction

    function automatic int ws_of(input int d);
        return (d == 0) ? int'(WS0) : int'(WS1);
    endfunction

    // Reference model: sequential memory in program order; latency from the wait-state count.
    function automatic void push_exp(input op_t o);
        exp_t        e;
        int          idx;
        logic [31:0] w;
        e.err  = !in_range(o.addr);
        e.lat  = e.err ? 2 : ws_of(cur) + 1;
        e.rd   = !o.wr;
        e.data = '0;
        if (!e.err) begin
            idx = int'((o.addr - BASE) >> 2);
            w   = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            if (o.wr) begin
                for (int b = 0; b < 4; b++)
                    if (o.mask[b]) w[8*b +: 8] = o.data[8*b +: 8];
                mem_m[idx] = w;
            end else begin
                e.data = w;
            end
        end
        exp_q.push_back(e);
    endfunction

    task automatic add(input logic [1:0] t, input logic [31:0] a, input logic w,
                       input logic [3:0] m, input logic [31:0] dt);
        op_t o;
        o.trans = t; o.addr = a; o.wr = w; o.mask = m; o.data = dt;
        ops.push_back(o);
    endtask

    task automatic wait_ready();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!hready[cur] && g < 20);
        if (!hready[cur]) begin
            vectors++;
            miscompares++;
            $display("FAIL hready_timeout dut%0d t=%0t: got 0 expected 1", cur, $time);
        end
    endtask

    // Pipelined master: each hready-high edge accepts the next address and ends the previous data phase.
    task automatic run_ops();
        op_t o, prev;
        bit  prev_v = 1'b0;
        prev = '{trans: HTRANS_IDLE, addr: '0, wr: 1'b0, mask: '0, data: '0};
        while (ops.size() > 0 || prev_v) begin
            if (ops.size() > 0) o = ops.pop_front();
            else o = '{trans: HTRANS_IDLE, addr: $urandom, wr: 1'b0, mask: '0, data: '0};
            htrans[cur] = o.trans;
            haddr[cur]  = o.addr;
            hwrite[cur] = o.wr;
            hmask[cur]  = o.mask;
            hwdata[cur] = (prev_v && prev.wr) ? prev.data : $urandom;
            wait_ready();
            @(posedge clk);
            prev_v = o.trans[1];
            if (prev_v) push_exp(o);
            prev = o;
            #1;
        end
    endtask

    task automatic reset_mid_write(input logic [31:0] a, input logic [31:0] dt);
        htrans[cur] = HTRANS_NONSEQ;
        haddr[cur]  = a;
        hwrite[cur] = 1'b1;
        hmask[cur]  = 4'hF;
        wait_ready();
        @(posedge clk);
        #1;
        hwdata[cur] = dt;
        htrans[cur] = HTRANS_IDLE;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cyc  = 0;
            hold = '0;
        end else if (exp_q.size() > 0) begin
            cyc++;
            if (hready[cur]) begin
                chk("latency", 32'(cyc), 32'(exp_q[0].lat));
                chk("hresp", 32'(hresp[cur]), 32'(exp_q[0].err));
                if (exp_q[0].rd && !exp_q[0].err) begin
                    chk("rdata", rdata[cur], exp_q[0].data);
                    hold[cur] = exp_q[0].data;
                end else begin
                    chk("data_hold", rdata[cur], hold[cur]);
                end
                void'(exp_q.pop_front());
                cyc = 0;
            end else begin
                chk("wait_hresp", 32'(hresp[cur]), 32'(exp_q[0].err));
                chk("wait_hold", rdata[cur], hold[cur]);
            end
        end else begin
            chk("idle_hready", 32'(hready[cur]), 32'h1);
            chk("idle_hresp", 32'(hresp[cur]), 32'h0);
            chk("idle_hold", rdata[cur], hold[cur]);
        end
    end

    initial begin
        rst_n  = 1'b0;
        htrans = '0;
        haddr  = '0;
        hwdata = '0;
        hwrite = '0;
        hmask  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cur = d;
            mem_m.delete();
            foreach (pool[i]) add(HTRANS_NONSEQ, pool[i], 1'b1, 4'hF, $urandom);
            add(HTRANS_NONSEQ, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
            add(HTRANS_SEQ,    32'h10, 1'b0, 4'hF, 32'h0);
            add(HTRANS_NONSEQ, 32'h20, 1'b1, 4'hF, 32'h11223344);
            add(HTRANS_NONSEQ, 32'h20, 1'b1, 4'b0010, 32'h0000_AB00);
            add(HTRANS_NONSEQ, 32'h20, 1'b0, 4'hF, 32'h0);
            add(HTRANS_NONSEQ, 32'h1000, 1'b0, 4'hF, 32'h0);
            add(HTRANS_NONSEQ, 32'h1000, 1'b1, 4'hF, $urandom);
            add(HTRANS_NONSEQ, 32'hFFFF_FFFC, 1'b1, 4'hF, $urandom);
            add(HTRANS_NONSEQ, 32'h0, 1'b0, 4'hF, 32'h0);
            add(HTRANS_NONSEQ, 32'hFFC, 1'b0, 4'hF, 32'h0);
            add(HTRANS_BUSY,   32'h4, 1'b1, 4'hF, $urandom);
            add(HTRANS_IDLE,   32'h4, 1'b1, 4'hF, $urandom);
            add(HTRANS_NONSEQ, 32'h4, 1'b0, 4'hF, 32'h0);
            add(HTRANS_NONSEQ, 32'h8, 1'b1, 4'b0000, $urandom);
            add(HTRANS_NONSEQ, 32'h8, 1'b0, 4'hF, 32'h0);
            run_ops();
            for (int n = 0; n < 200; n++) begin
                int unsigned r = $urandom_range(0, 9);
                logic [1:0]  t = (r < 6) ? HTRANS_NONSEQ : (r < 8) ? HTRANS_SEQ :
                                 (r == 8) ? HTRANS_IDLE : HTRANS_BUSY;
                logic [31:0] a = ($urandom_range(0, 99) < 85) ? pool[$urandom_range(0, 7)]
                                                              : bad[$urandom_range(0, 3)];
                add(t, a, 1'($urandom), 4'($urandom), $urandom);
            end
            run_ops();
            reset_mid_write(32'h14, 32'hCAFEF00D);
            add(HTRANS_NONSEQ, 32'h14, 1'b0, 4'hF, 32'h0);
            run_ops();
        end
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
